fma_align_seq: RTL

Multi-cycle addend alignment stage for the FMA datapath, directly downstream of the product-exponent adder. It takes the product exponent Pe, the addend exponent Ze and the addend significand Zm, and computes the alignment count. It then right-shifts Zm into the 3NF+4-bit sum window one shift stage per cycle, accumulating a sticky bit. Results are handed to the significand adder over a valid/ready handshake.

---
 rtl/fma_align_seq.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/fma_align_seq.sv
// rtl/fma_align_seq.sv - multi-cycle FMA addend alignment stage (log shifter, one stage per cycle)
//
// Purpose: computes ACnt = Pe - Ze + (NF+2), classifies the addend (zero, product
// killed, addend shifted out, or normal shift), then right-shifts the preshifted
// addend {Zm, (2NF+3)'b0} by ACnt using one binary-weighted stage per cycle while
// collecting a sticky bit. The result is handed downstream over valid/ready.
//
// Ports:
//   clk       clock, rising edge
//   reset_n   asynchronous active-low reset
//   Flush     synchronous abort, back to IDLE, in-flight operation discarded
//   InValid   upstream operands valid
//   InReady   block can accept operands (IDLE only)
//   Pe        product exponent, NE+2 bits, already biased
//   Ze        addend exponent, NE bits
//   Zm        addend significand incl. implicit bit, NF+1 bits
//   PZero     product is zero
//   ZZero     addend is zero
//   OutValid  result available (DONE)
//   OutReady  downstream accepts the result
//   Am        aligned addend significand, 3NF+4 bits
//   ASticky   OR of bits shifted below Am[0], or of the killed operand
//   KillProd  product too small to matter, sum is the addend
//   KillZ     addend zero or shifted entirely out

module fma_align_seq #(
    parameter int NE   = 11,
    parameter int NF   = 52,
    parameter int BIAS = 1023
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              Flush,
    input  logic              InValid,
    output logic              InReady,
    input  logic [NE+1:0]     Pe,
    input  logic [NE-1:0]     Ze,
    input  logic [NF:0]       Zm,
    input  logic              PZero,
    input  logic              ZZero,
    output logic              OutValid,
    input  logic              OutReady,
    output logic [3*NF+3:0]   Am,
    output logic              ASticky,
    output logic              KillProd,
    output logic              KillZ
);

    localparam int W  = 3 * NF + 4;
    localparam int L  = $clog2(W);
    localparam int CW = (L > 1) ? $clog2(L) : 1;
    localparam logic [NE+1:0] ACNT_OFFS = (NE + 2)'(NF + 2);

    // Pe arrives biased, so BIAS never enters the arithmetic; it only has to
    // agree with the exponent width the rest of the datapath was built for.
    if (BIAS != (1 << (NE - 1)) - 1) begin : g_bias_check
        $error("BIAS does not match NE");
    end

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [CW-1:0]   cnt;
    logic [L-1:0]    acnt_r;

    logic            accept;
    logic [NE+1:0]   acnt_in;
    logic            acnt_neg;
    logic            acnt_big;
    logic            shift_path;
    logic [W-1:0]    preshift;
    logic            last_step;
    logic [L:0]      step_amt;
    logic [W-1:0]    step_mask;

    assign accept     = InValid & InReady;
    assign acnt_in    = Pe - {2'b00, Ze} + ACNT_OFFS;
    assign acnt_neg   = acnt_in[NE+1];
    // Unsigned compare is only meaningful once the sign bit is known clear.
    assign acnt_big   = !acnt_neg && (acnt_in > (NE + 2)'(W - 1));
    assign shift_path = !ZZero && !acnt_neg && !acnt_big;
    assign preshift   = {Zm, {(2 * NF + 3){1'b0}}};
    assign last_step  = (cnt == CW'(L - 1));

    // On the shift path ACnt <= W-1 < 2^L, so only its low L bits are kept and
    // bit cnt selects whether this cycle's 2^cnt stage shifts.
    assign step_amt   = acnt_r[cnt] ? ((L + 1)'(1) << cnt) : '0;
    assign step_mask  = ~({W{1'b1}} << step_amt);

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; Flush overrides every transition
    always_comb begin
        state_nxt = state;
        if (Flush) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    if (accept) state_nxt = shift_path ? SHIFT : DONE;
                SHIFT:   if (last_step) state_nxt = DONE;
                DONE:    if (OutReady) state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Handshake outputs
    always_comb begin
        InReady  = (state == IDLE);
        OutValid = (state == DONE);
    end

    // Datapath: classification on accept, one shifter stage per SHIFT cycle.
    // Am doubles as the shift working register; it is only qualified by OutValid.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt      <= '0;
            acnt_r   <= '0;
            Am       <= '0;
            ASticky  <= 1'b0;
            KillProd <= 1'b0;
            KillZ    <= 1'b0;
        end else if (Flush) begin
            cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        cnt    <= '0;
                        acnt_r <= acnt_in[L-1:0];
                        if (ZZero) begin
                            Am       <= '0;
                            ASticky  <= 1'b0;
                            KillProd <= 1'b0;
                            KillZ    <= 1'b1;
                        end else if (acnt_neg) begin
                            Am       <= preshift;
                            ASticky  <= ~PZero;
                            KillProd <= 1'b1;
                            KillZ    <= 1'b0;
                        end else if (acnt_big) begin
                            Am       <= '0;
                            ASticky  <= 1'b1;
                            KillProd <= 1'b0;
                            KillZ    <= 1'b1;
                        end else begin
                            Am       <= preshift;
                            ASticky  <= 1'b0;
                            KillProd <= 1'b0;
                            KillZ    <= 1'b0;
                        end
                    end
                end
                SHIFT: begin
                    Am      <= Am >> step_amt;
                    ASticky <= ASticky | (|(Am & step_mask));
                    cnt     <= last_step ? '0 : cnt + CW'(1);
                end
                default: begin
                end
            endcase
        end
    end

endmodule
